lut_layer_stream: RTL
=====================

Name: lut_layer_stream

Overview:
- Parametrised successor to the single fixed-table LogicNets neuron.
- Holds N_NEURONS LUT neurons, each mapping an IN_BITS-wide input word to an OUT_BITS-wide output.
- Truth tables are runtime-loadable through a config port instead of hard-coded.
- Lookups are pipelined behind valid/ready handshakes; the block sits between quantised feature buses in a streaming inference chain.

Parameters:
- N_NEURONS, 4, number of independent neurons (channels)
- IN_BITS, 6, address width per neuron; table depth is 2**IN_BITS
- OUT_BITS, 1, output width per neuron
- NID_W, 2, neuron-index width; must satisfy 2**NID_W >= N_NEURONS

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: enter LOAD and clear the load counter
- cfg_we  in  1  table write strobe; honoured only in LOAD
- cfg_nid  in  NID_W  target neuron
- cfg_addr  in  IN_BITS  table entry
- cfg_data  in  OUT_BITS  entry value
- cfg_commit  in  1  pulse: request LOAD->RUN
- cfg_busy  out  1  high while in DRAIN or LOAD
- cfg_err  out  1  sticky; set by a bad commit or an out-of-range nid
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts the input word
- in_data  in  N_NEURONS*IN_BITS  neuron k address at bits [k*IN_BITS +: IN_BITS]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  N_NEURONS*OUT_BITS  neuron k result at bits [k*OUT_BITS +: OUT_BITS]

Behaviour:
- Reset values: state=UNCFG; out_valid=0; out_data=0; s1_valid=0; cfg_err=0; cfg_busy=0; load counter=0.
- Table storage is not reset; its contents are undefined until loaded.
- States: UNCFG, DRAIN, LOAD, RUN.
  - UNCFG: in_ready=0. cfg_start -> LOAD.
  - RUN: streaming active. cfg_start -> DRAIN.
  - DRAIN: in_ready=0. Stay until s1_valid=0 and out_valid=0, then -> LOAD.
  - LOAD: each cfg_we writes table[cfg_nid][cfg_addr]=cfg_data and increments the load counter (saturating). A cfg_we with cfg_nid >= N_NEURONS is ignored and sets cfg_err.
  - cfg_commit in LOAD: if counter >= N_NEURONS*2**IN_BITS, go to RUN; otherwise set cfg_err and stay in LOAD. The counter counts writes, not distinct entries.
  - cfg_start while already in LOAD: counter cleared, tables untouched.
  - cfg_we and cfg_commit outside LOAD: ignored.
  - cfg_commit and cfg_we in the same cycle: the write is applied and counted first, then commit is evaluated on the updated count.
  - cfg_err clears only on rst or on cfg_start.
- Pipeline has 2 stages with latency exactly 2 cycles from the accept edge to out_valid when there is no stall.
  - Stage 1 registers in_data. Stage 2 registers the lookup results into out_data.
- Handshake:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = (state==RUN) && adv1.
  - Transfers occur on valid && ready.
  - out_data is held stable while out_valid && !out_ready.
  - Full throughput of 1 word per cycle when out_ready is continuously high.
  - No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.
- Simultaneous cfg_start and an input accept in RUN: the word is accepted, then the block drains.
- Reset mid-operation: in-flight data is discarded and the block returns to UNCFG; tables must be reloaded before RUN.

Decomposition:
- Package lut_layer_pkg holds:
  - state enum {UNCFG, DRAIN, LOAD, RUN};
  - function depth(IN_BITS) = 2**IN_BITS;
  - localparam TOTAL_ENTRIES.
- One sub-module, lut_neuron_ram:
  - one neuron's 2**IN_BITS x OUT_BITS distributed table;
  - one synchronous write port and one asynchronous read;
  - instantiated N_NEURONS times in a generate loop.

Test Plan:
- Load neuron k with table[a]=parity(a)^k (N=4, IN=6, OUT=1), commit, stream 64 words with neuron k fed address a -> out_data matches model, out_valid 2 cycles after the first accept, 64 results in 64 consecutive cycles.
- Commit after only 255 of 256 writes -> cfg_err=1 and state stays LOAD; one more write then commit -> RUN, with cfg_err still 1 until the next cfg_start.
- Hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0 and out_data stable; release -> no words lost or duplicated, order preserved.
- cfg_start in RUN with 2 words in flight -> cfg_busy=1, both words are delivered, then LOAD; reload inverted tables, commit, and later outputs are inverted.
- cfg_we with cfg_nid=3 and N_NEURONS=3 -> write ignored and cfg_err=1.
- rst asserted mid-stream -> out_valid=0 and out_data=0 immediately (asynchronous); state UNCFG with in_ready=0.

Source files
------------

// File: rtl/lut_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_layer_pkg
// Purpose  : Shared types and helpers for the streaming LUT neuron layer.
//            - state_t        : block operating state
//            - depth()        : table depth for a given address width
//            - TOTAL_ENTRIES  : table entries of the default layer geometry
// Revision : 1.0  initial release
// ============================================================================
package lut_layer_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    function automatic int depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_IN_BITS   = 6;
    localparam int TOTAL_ENTRIES = DEF_N_NEURONS * depth(DEF_IN_BITS);

endpackage
`default_nettype wire

// File: rtl/lut_neuron_ram.sv
`default_nettype none
// ============================================================================
// Module   : lut_neuron_ram
// Purpose  : Truth table of one LUT neuron, 2**IN_BITS x OUT_BITS entries.
//            One synchronous write port, one asynchronous read port.
//            Contents are not reset and are undefined until written.
// Ports    : clk      - clock
//            i_we     - write strobe
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address
//            o_rdata  - read data (combinational)
// Revision : 1.0  initial release
// ============================================================================
module lut_neuron_ram
    import lut_layer_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic [IN_BITS-1:0]  i_raddr,
    output logic [OUT_BITS-1:0] o_rdata
);

    localparam int c_depth = depth(IN_BITS);

    logic [OUT_BITS-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lut_layer_stream.sv
`default_nettype none
// ============================================================================
// Module   : lut_layer_stream
// Purpose  : Layer of N_NEURONS runtime-loadable LUT neurons behind a
//            two-stage valid/ready pipeline.
//            Stage 1 registers the input word, stage 2 registers the table
//            lookups. Tables are loaded through the cfg_* port while the
//            block is in LOAD; cfg_commit moves to RUN once enough writes
//            have been counted.
// Ports    : clk, rst                 - clock, async active-high reset
//            cfg_start / cfg_commit   - enter LOAD / request LOAD->RUN
//            cfg_we, cfg_nid,
//            cfg_addr, cfg_data       - table write port
//            cfg_busy                 - high in DRAIN or LOAD
//            cfg_err                  - sticky configuration error
//            in_valid/in_ready/in_data    - input stream
//            out_valid/out_ready/out_data - output stream
// Revision : 1.0  initial release
// ============================================================================
module lut_layer_stream
    import lut_layer_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1,
    parameter int NID_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic                          cfg_we,
    input  logic [NID_W-1:0]              cfg_nid,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    input  logic                          cfg_commit,
    output logic                          cfg_busy,
    output logic                          cfg_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data
);

    localparam int c_total_entries = N_NEURONS * depth(IN_BITS);
    localparam int c_cnt_w         = $clog2(c_total_entries + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_total_entries);

    state_t                          r_state;
    state_t                          w_state_next;
    logic [c_cnt_w-1:0]              r_load_cnt;
    logic [c_cnt_w-1:0]              w_load_cnt_next;
    logic                            r_cfg_err;

    logic                            w_in_load;
    logic                            w_nid_ok;
    logic                            w_we_ok;
    logic                            w_we_bad;
    logic                            w_commit_req;
    logic                            w_commit_ok;
    logic                            w_commit_bad;
    logic [N_NEURONS-1:0]            w_ram_we;

    logic                            r_s1_valid;
    logic [N_NEURONS*IN_BITS-1:0]    r_s1_data;
    logic                            r_out_valid;
    logic [N_NEURONS*OUT_BITS-1:0]   r_out_data;
    logic [N_NEURONS*OUT_BITS-1:0]   w_lookup;
    logic                            w_adv1;
    logic                            w_adv2;
    logic                            w_accept;

    // ------------------------------------------------------------------
    // Configuration path
    // ------------------------------------------------------------------
    assign w_in_load = (r_state == LOAD);
    assign w_nid_ok  = (32'(cfg_nid) < 32'(N_NEURONS));
    assign w_we_ok   = w_in_load && cfg_we && w_nid_ok;
    assign w_we_bad  = w_in_load && cfg_we && !w_nid_ok;

    // Saturates at the full-table count; only the ">= full" test matters.
    assign w_load_cnt_next = (w_we_ok && (r_load_cnt != c_cnt_full))
                           ? r_load_cnt + c_cnt_w'(1) : r_load_cnt;

    // A same-cycle write is counted before the commit is judged. A restart
    // in the same cycle takes precedence and discards the commit.
    assign w_commit_req = w_in_load && cfg_commit && !cfg_start;
    assign w_commit_ok  = w_commit_req && (w_load_cnt_next >= c_cnt_full);
    assign w_commit_bad = w_commit_req && (w_load_cnt_next <  c_cnt_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_cnt <= '0;
        end else if (cfg_start) begin
            r_load_cnt <= '0;
        end else begin
            r_load_cnt <= w_load_cnt_next;
        end
    end

    // Error-setting events win over a simultaneous clear by cfg_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (w_we_bad || w_commit_bad) begin
            r_cfg_err <= 1'b1;
        end else if (cfg_start) begin
            r_cfg_err <= 1'b0;
        end
    end

    assign cfg_err = r_cfg_err;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cfg_busy     = 1'b0;
        case (r_state)
            UNCFG: begin
                if (cfg_start) begin
                    w_state_next = LOAD;
                end
            end
            DRAIN: begin
                cfg_busy = 1'b1;
                if (!r_s1_valid && !r_out_valid) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                cfg_busy = 1'b1;
                if (w_commit_ok) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                in_ready = w_adv1;
                if (cfg_start) begin
                    w_state_next = DRAIN;
                end
            end
            default: begin
                w_state_next = UNCFG;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_data <= in_data;
                end
            end
            // out_data only changes on advance, so it holds under stall.
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_lookup;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Neuron tables
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        assign w_ram_we[k] = w_we_ok && (cfg_nid == NID_W'(k));

        lut_neuron_ram #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_ram_we[k]),
            .i_waddr (cfg_addr),
            .i_wdata (cfg_data),
            .i_raddr (r_s1_data[k*IN_BITS +: IN_BITS]),
            .o_rdata (w_lookup[k*OUT_BITS +: OUT_BITS])
        );
    end

endmodule
`default_nettype wire
